// File: rtl/sram_slot_arbiter.sv
// Time-slices one asynchronous SRAM between a real-time channel that owns every even
// slot and round-robin best-effort channels; three-stage ARB/ACCESS/RETURN pipeline.
module sram_slot_arbiter #(
  parameter int NUM_CH        = 3,
  parameter int ADDR_W        = 20,
  parameter int DATA_W        = 32,
  parameter int RT_CH         = 0,
  parameter bit WORK_CONSERVE = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          req,
  input  logic [NUM_CH-1:0]          we,
  input  logic [NUM_CH*ADDR_W-1:0]   addr,
  input  logic [NUM_CH*DATA_W-1:0]   wdata,
  input  logic [NUM_CH*DATA_W/8-1:0] be,
  output logic [NUM_CH-1:0]          gnt,
  output logic [NUM_CH-1:0]          rvalid,
  output logic [NUM_CH*DATA_W-1:0]   rdata,
  output logic [ADDR_W-1:0]          sram_addr,
  inout  wire  [DATA_W-1:0]          sram_data,
  output logic                       sram_ce_n,
  output logic                       sram_oe_n,
  output logic                       sram_we_n,
  output logic [DATA_W/8-1:0]        sram_be_n
);
  localparam int BE_W = DATA_W / 8;
  localparam int CH_W = $clog2(NUM_CH);
  localparam logic SLOT_EVEN = 1'b0;
  localparam logic [CH_W-1:0] RT_IDX = CH_W'(RT_CH);

  logic            slot;
  logic [CH_W-1:0] rrPtr;
  logic            rrValid;
  logic [CH_W-1:0] rrCh;
  logic            gntValid;
  logic            gntIsRr;
  logic [CH_W-1:0] gntCh;
  logic            readPend;
  logic [CH_W-1:0] readCh;
  logic            driveEn;
  logic [DATA_W-1:0] driveData;

  // Best-effort search: rrPtr+1 upward, wrapping, skipping the real-time channel.
  // NOTE: every output of a combinational block gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    int idx;
    rrValid = 1'b0;
    rrCh    = rrPtr;
    idx     = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = int'(rrPtr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!rrValid && idx != RT_CH && req[CH_W'(idx)]) begin
        rrValid = 1'b1;
        rrCh    = CH_W'(idx);
      end
    end
  end

  always_comb begin
    gntValid = 1'b0;
    gntIsRr  = 1'b0;
    gntCh    = RT_IDX;
    if (slot == SLOT_EVEN) begin
      if (req[RT_IDX]) begin
        gntValid = 1'b1;
      end else if (WORK_CONSERVE && rrValid) begin
        gntValid = 1'b1;
        gntIsRr  = 1'b1;
        gntCh    = rrCh;
      end
    end else begin
      if (rrValid) begin
        gntValid = 1'b1;
        gntIsRr  = 1'b1;
        gntCh    = rrCh;
      end else if (WORK_CONSERVE && req[RT_IDX]) begin
        gntValid = 1'b1;
      end
    end
    // The grant is combinational, so it must also be suppressed while reset is held.
    if (!rst) begin
      gntValid = 1'b0;
      gntIsRr  = 1'b0;
    end
  end

  always_comb begin
    gnt = '0;
    if (gntValid) gnt[gntCh] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot      <= SLOT_EVEN;
      rrPtr     <= RT_IDX;
      readPend  <= 1'b0;
      readCh    <= '0;
      driveEn   <= 1'b0;
      driveData <= '0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_be_n <= '1;
      sram_addr <= '0;
    end else begin
      slot      <= ~slot;
      if (gntIsRr) rrPtr <= gntCh;
      readPend  <= gntValid && !we[gntCh];
      readCh    <= gntCh;
      driveEn   <= gntValid && we[gntCh];
      sram_ce_n <= !gntValid;
      sram_oe_n <= !(gntValid && !we[gntCh]);
      sram_we_n <= !(gntValid && we[gntCh]);
      sram_be_n <= gntValid ? ~be[gntCh*BE_W +: BE_W] : '1;
      if (gntValid) begin
        sram_addr <= addr[gntCh*ADDR_W +: ADDR_W];
        driveData <= wdata[gntCh*DATA_W +: DATA_W];
      end
    end
  end

  // Read data is captured at the end of the access cycle; clearing readPend on reset is
  // what drops an in-flight read.
  // NOTE: rdata is a per-channel register bank, not a RAM, so it is reset like any flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid <= '0;
      rdata  <= '0;
    end else begin
      rvalid <= '0;
      if (readPend) begin
        rvalid[readCh]                  <= 1'b1;
        rdata[readCh*DATA_W +: DATA_W] <= sram_data;
      end
    end
  end

  assign sram_data = driveEn ? driveData : {DATA_W{1'bz}};

endmodule
